// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc4} entries
// with first-word fall-through, flush on redirect, and asynchronous reset.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc4,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc4,
  input  logic                       out_ready,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("if_id_queue: DEPTH must be a power of two in 2..16");
  end

  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc4   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Handshake flags come only from registered count, so out_ready never reaches in_ready.
  assign w_in_ready  = (r_count != (AW+1)'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready && !Flush;
  assign w_pop       = w_out_valid && out_ready && !Flush;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; its contents are masked whenever the queue is empty.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc4[r_wr_ptr]   <= in_pc4;
    end
  end

  always_comb begin
    out_instr = NOP;
    out_pc4   = '0;
    if (w_out_valid) begin
      out_instr = r_mem_instr[r_rd_ptr];
      out_pc4   = r_mem_pc4[r_rd_ptr];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4) with hand-computed expectations.
module tb_if_id_queue;

  localparam logic [31:0] TB_NOP = 32'h00000013;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic        out_ready;
  logic        Flush;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  if_id_queue #(.DEPTH(4), .NOP(TB_NOP)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc4(in_pc4), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4), .out_ready(out_ready),
    .Flush(Flush), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1 - 32'd1);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_instr"}, out_instr, TB_NOP);
    chk({tag, ".out_pc4"}, out_pc4, 32'h0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_instr"}, out_instr, ins);
    chk({tag, ".out_pc4"}, out_pc4, pc);
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
    out_ready = 1'b0; Flush = 1'b0;
    #1;
    chk_empty("reset");
    #12 Reset = 1'b0;

    // Single push into empty queue is visible right after the edge
    in_valid = 1'b1; in_instr = 32'h20080005; in_pc4 = 32'h00003004;
    tick();
    in_valid = 1'b0;
    chk_head("single", 32'h20080005, 32'h00003004);
    chk("single.count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_empty("single_drain");

    // Fill past full: E must be dropped
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hA0000000 + 32'(i);
      in_pc4   = 32'h00001000 + 32'(4 * i);
      tick();
      if (i == 3) begin
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.count", 32'(count), 32'd4);
      end
    end
    in_valid = 1'b0;
    chk("full_after_E.count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("drain%0d", i), 32'hA0000000 + 32'(i), 32'h00001000 + 32'(4 * i));
      tick();
      if (i == 0) chk("full_pop.in_ready", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    chk_empty("full_drained");

    // Steady-state push+pop at count=2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'hB0000000 + 32'(i); in_pc4 = 32'h00002000 + 32'(4 * i);
      tick();
    end
    chk("stream_pre.count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instr = 32'hB0000000 + 32'(i + 2); in_pc4 = 32'h00002000 + 32'(4 * (i + 2));
      chk_head($sformatf("stream%0d", i), 32'hB0000000 + 32'(i), 32'h00002000 + 32'(4 * i));
      tick();
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    chk_head("stream_tail6", 32'hB0000006, 32'h00002018);
    tick();
    chk_head("stream_tail7", 32'hB0000007, 32'h0000201C);
    tick();
    out_ready = 1'b0;
    chk_empty("stream_drained");

    // Flush wins over simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'hC0000000 + 32'(i); in_pc4 = 32'h00003000 + 32'(4 * i);
      tick();
    end
    chk("preflush.count", 32'(count), 32'd3);
    Flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hDEADBEEF; in_pc4 = 32'h0000BEEF;
    chk("flush_cycle.in_ready", 32'(in_ready), 32'd1);
    chk("flush_cycle.out_valid", 32'(out_valid), 32'd1);
    tick();
    Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty("flush");
    in_valid = 1'b1; in_instr = 32'h12345678; in_pc4 = 32'h00004004;
    tick();
    in_valid = 1'b0;
    chk_head("post_flush", 32'h12345678, 32'h00004004);
    chk("post_flush.count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset pulse between edges
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'hE0000000 + 32'(i); in_pc4 = 32'h00005000 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0;
    chk("prereset.count", 32'(count), 32'd2);
    #2 Reset = 1'b1;
    #1;
    chk_empty("async_reset");
    Reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0F0F0F0F; in_pc4 = 32'h00006004;
    tick();
    in_valid = 1'b0;
    chk_head("post_reset", 32'h0F0F0F0F, 32'h00006004);
    chk("post_reset.count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();

    // Pops on an empty queue must not underflow or move rd_ptr
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_empty($sformatf("underflow%0d", i));
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h77777777; in_pc4 = 32'h00007004;
    tick();
    in_valid = 1'b0;
    chk_head("after_underflow", 32'h77777777, 32'h00007004);
    chk("after_underflow.count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter NOP, default 32'h00000000, instruction word driven on out_instr while empty.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch stage offers a word this cycle.
REQ-006 in_instr  input  32  fetched instruction.
REQ-007 in_pc4  input  32  PC+4 of the fetched instruction.
REQ-008 in_ready  output  1  queue can accept a word this cycle.
REQ-009 out_valid  output  1  head entry is valid for decode.
REQ-010 out_instr  output  32  head instruction.
REQ-011 out_pc4  output  32  head PC+4.
REQ-012 out_ready  input  1  decode consumes the head this cycle.
REQ-013 Flush  input  1  discard all queued entries (taken branch/jump redirect).
REQ-014 count  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH {instr, pc4} entries with wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready && !Flush; entry written at wr_ptr, wr_ptr increments.
REQ-017 Pop SHALL occur on a rising edge when out_valid && out_ready && !Flush; rd_ptr increments.
REQ-018 in_ready SHALL equal (count != DEPTH), decoded from registered state only; no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 First-word fall-through: out_instr/out_pc4 SHALL show mem[rd_ptr] combinationally when out_valid=1; NOP and 32'h0 when out_valid=0.
REQ-021 Latency: a word pushed at edge k SHALL be visible on the outputs after edge k if the queue was empty.
REQ-022 count update: push only +1; pop only -1; simultaneous push and pop unchanged (both pointers advance); neither unchanged.
REQ-023 Full (count=DEPTH): in_valid SHALL be ignored; pop proceeds normally and in_ready rises the following cycle.
REQ-024 Empty (count=0): out_ready SHALL be ignored; no underflow, rd_ptr unchanged.
REQ-025 Flush SHALL take priority over push and pop: at the edge, count, wr_ptr and rd_ptr become 0 and any word offered that cycle is discarded.
REQ-026 Entries SHALL leave in push order; no reordering, duplication or loss except by Flush or Reset.
REQ-027 in_ready and out_valid are independent of in_valid and Flush within the same cycle.

Reset
REQ-028 Reset=1 SHALL immediately, without a clock edge, force count=0, wr_ptr=0, rd_ptr=0, out_valid=0, in_ready=1, out_instr=NOP, out_pc4=0.
REQ-029 Storage contents need not be reset; they SHALL never be observable while out_valid=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL appear at the head.

Verification
REQ-031 Reset, then push {32'h20080005, 32'h00003004} with out_ready=0 -> after the edge: out_valid=1, out_instr=32'h20080005, out_pc4=32'h00003004, count=1.
REQ-032 Push 5 words A..E (DEPTH=4) with out_ready=0 -> in_ready=0 after the 4th push, E dropped, count=4; then out_ready=1 for 4 cycles -> A,B,C,D in order, then out_valid=0, out_instr=NOP.
REQ-033 count=2, simultaneous push and pop for 6 cycles -> count stays 2, order preserved across pointer wrap.
REQ-034 count=3, Flush=1 together with in_valid=1 and out_ready=1 -> after the edge: count=0, out_valid=0, in_ready=1, offered word absent.
REQ-035 count=2, Reset pulsed between clock edges -> outputs reach reset values before the next edge; next push appears at the head with count=1.
REQ-036 Empty queue, out_ready=1 held for 3 cycles -> count stays 0, rd_ptr unchanged, outputs NOP/0.
